// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline: ALU op classes,
// datapath widths and the bundled per-instruction control record.
package mips_pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10
    } aluOp_e;

    typedef struct packed {
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   memToReg;
        logic   aluSrc;
        logic   regDst;
        aluOp_e aluOp;
    } ctrl_t;

endpackage

// File: rtl/load_use_hazard_detect.sv
// Load-use hazard detection: stalls the front end for one cycle when the load in
// EX writes a register read by the instruction in IF/ID, unless ID is squashed.
module load_use_hazard_detect
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_W = mips_pipe_pkg::REG_W
) (
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRegisterRt,
    input  logic [REG_W-1:0] ifIdRegisterRs,
    input  logic [REG_W-1:0] ifIdRegisterRt,
    input  logic             flush,
    output logic             loadUse,
    output logic             stall,
    output logic             pcWrite,
    output logic             ifIdWrite
);

    // $0 is hard-wired, so a load targeting it can never create a dependency.
    assign loadUse = exMemRead && (exRegisterRt != '0) &&
                     ((exRegisterRt == ifIdRegisterRs) || (exRegisterRt == ifIdRegisterRt));

    assign stall     = loadUse && !flush;
    assign pcWrite   = !stall;
    assign ifIdWrite = !stall;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion on
// stall or flush, and a saturating count of stall cycles.
module id_ex_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = mips_pipe_pkg::DATA_W,
    parameter int unsigned REG_W  = mips_pipe_pkg::REG_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  IF_IdRegisterRs,
    input  logic [REG_W-1:0]  IF_IdRegisterRt,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdMemToReg,
    input  logic              IdALUSrc,
    input  logic              IdRegDst,
    input  logic [1:0]        IdALUOp,
    input  logic [DATA_W-1:0] IdReadData1,
    input  logic [DATA_W-1:0] IdReadData2,
    input  logic [DATA_W-1:0] IdSignExtImm,
    input  logic [REG_W-1:0]  IdRs,
    input  logic [REG_W-1:0]  IdRt,
    input  logic [REG_W-1:0]  IdRd,
    input  logic              flush,
    output logic              ID_ExRegWrite,
    output logic              ID_ExMemRead,
    output logic              ID_ExMemWrite,
    output logic              ID_ExMemToReg,
    output logic              ID_ExALUSrc,
    output logic              ID_ExRegDst,
    output logic [1:0]        ID_ExALUOp,
    output logic [DATA_W-1:0] ID_ExReadData1,
    output logic [DATA_W-1:0] ID_ExReadData2,
    output logic [DATA_W-1:0] ID_ExSignExtImm,
    output logic [REG_W-1:0]  ID_ExRegisterRs,
    output logic [REG_W-1:0]  ID_ExRegisterRt,
    output logic [REG_W-1:0]  ID_ExRegisterRd,
    output logic              pcWrite,
    output logic              IF_IdWrite,
    output logic              stall,
    output logic [CNT_W-1:0]  stallCount
);

    ctrl_t             idCtrl;
    ctrl_t             exCtrl;
    logic [DATA_W-1:0] exReadData1;
    logic [DATA_W-1:0] exReadData2;
    logic [DATA_W-1:0] exSignExtImm;
    logic [REG_W-1:0]  exRs;
    logic [REG_W-1:0]  exRt;
    logic [REG_W-1:0]  exRd;
    logic [CNT_W-1:0]  stallCnt;
    logic              loadUse;

    assign idCtrl = '{
        regWrite: IdRegWrite,
        memRead:  IdMemRead,
        memWrite: IdMemWrite,
        memToReg: IdMemToReg,
        aluSrc:   IdALUSrc,
        regDst:   IdRegDst,
        aluOp:    aluOp_e'(IdALUOp)
    };

    load_use_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .exMemRead      (exCtrl.memRead),
        .exRegisterRt   (exRt),
        .ifIdRegisterRs (IF_IdRegisterRs),
        .ifIdRegisterRt (IF_IdRegisterRt),
        .flush          (flush),
        .loadUse        (loadUse),
        .stall          (stall),
        .pcWrite        (pcWrite),
        .ifIdWrite      (IF_IdWrite)
    );

    // flush || loadUse covers both bubble causes; only true stalls are counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exCtrl       <= '0;
            exReadData1  <= '0;
            exReadData2  <= '0;
            exSignExtImm <= '0;
            exRs         <= '0;
            exRt         <= '0;
            exRd         <= '0;
            stallCnt     <= '0;
        end else begin
            if (flush || loadUse) begin
                exCtrl       <= '0;
                exReadData1  <= '0;
                exReadData2  <= '0;
                exSignExtImm <= '0;
                exRs         <= '0;
                exRt         <= '0;
                exRd         <= '0;
            end else begin
                exCtrl       <= idCtrl;
                exReadData1  <= IdReadData1;
                exReadData2  <= IdReadData2;
                exSignExtImm <= IdSignExtImm;
                exRs         <= IdRs;
                exRt         <= IdRt;
                exRd         <= IdRd;
            end
            if (stall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end

    assign ID_ExRegWrite   = exCtrl.regWrite;
    assign ID_ExMemRead    = exCtrl.memRead;
    assign ID_ExMemWrite   = exCtrl.memWrite;
    assign ID_ExMemToReg   = exCtrl.memToReg;
    assign ID_ExALUSrc     = exCtrl.aluSrc;
    assign ID_ExRegDst     = exCtrl.regDst;
    assign ID_ExALUOp      = exCtrl.aluOp;
    assign ID_ExReadData1  = exReadData1;
    assign ID_ExReadData2  = exReadData2;
    assign ID_ExSignExtImm = exSignExtImm;
    assign ID_ExRegisterRs = exRs;
    assign ID_ExRegisterRt = exRt;
    assign ID_ExRegisterRd = exRd;
    assign stallCount      = stallCnt;

endmodule
